// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: four-requester round-robin scheduler in front of a serial
// binary-to-BCD converter (shift-add-3, one bit per cycle, 16 iterations).
// Handshake: a requester holds req[n] high with a stable binN operand; the
// operand is captured on the grant edge and ack[n] pulses for the following
// cycle. Each result is presented for exactly one cycle with dout_valid high,
// tagged with dout_id. The data outputs hold until the next result.
module bcd_conv_sched #(
   parameter bit SAT_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [15:0] bin0,
   input  logic [15:0] bin1,
   input  logic [15:0] bin2,
   input  logic [15:0] bin3,
   output logic [3:0]  ack,
   output logic        busy,
   output logic        dout_valid,
   output logic [1:0]  dout_id,
   output logic [15:0] dout_bcd,
   output logic        dout_ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [1:0]  ptr_q;
   logic [1:0]  gnt_q;
   logic [3:0]  cnt_q;
   logic [19:0] acc_q;
   logic [15:0] opr_q;
   logic [3:0]  ack_q;
   logic        valid_q;
   logic [1:0]  id_q;
   logic [15:0] bcd_q;
   logic        ovf_q;

   logic        arb_hit_d;
   logic [1:0]  arb_idx_d;
   logic [15:0] sel_bin_d;
   logic [19:0] acc_adj_d;
   logic [19:0] acc_d;
   logic [15:0] opr_d;
   logic        res_ovf_d;
   logic [15:0] res_bcd_d;

   // Round-robin search: first requester at or after ptr (mod 4) wins.
   always_comb begin
      logic [1:0] cand;
      arb_hit_d = 1'b0;
      arb_idx_d = ptr_q;
      cand      = ptr_q;
      for (int i = 0; i < 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!arb_hit_d && req[cand]) begin
            arb_hit_d = 1'b1;
            arb_idx_d = cand;
         end
      end
   end

   // Operand of the requester that would be granted this cycle.
   always_comb begin
      case (arb_idx_d)
         2'd0:    sel_bin_d = bin0;
         2'd1:    sel_bin_d = bin1;
         2'd2:    sel_bin_d = bin2;
         default: sel_bin_d = bin3;
      endcase
   end

   // One shift-add-3 step: correct every digit >= 5, then shift the operand
   // MSB into the accumulator. The final-step result feeds the output regs
   // directly so the answer is registered on the 16th iteration edge.
   always_comb begin
      acc_adj_d = acc_q;
      for (int d = 0; d < 5; d++) begin
         if (acc_q[4*d +: 4] >= 4'd5) begin
            acc_adj_d[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
         end
      end
      acc_d     = {acc_adj_d[18:0], opr_q[15]};
      opr_d     = {opr_q[14:0], 1'b0};
      // Lower four digits are always legal BCD, so only the fifth digit
      // can signal a value above 9999.
      res_ovf_d = |acc_d[19:16];
      res_bcd_d = (SAT_EN && res_ovf_d) ? 16'h9999 : acc_d[15:0];
   end

   // Scheduler/converter FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         gnt_q   <= 2'd0;
         cnt_q   <= 4'd0;
         acc_q   <= 20'd0;
         opr_q   <= 16'd0;
         ack_q   <= 4'd0;
         valid_q <= 1'b0;
         id_q    <= 2'd0;
         bcd_q   <= 16'd0;
         ovf_q   <= 1'b0;
      end else begin
         ack_q   <= 4'd0;
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (arb_hit_d) begin
                  gnt_q   <= arb_idx_d;
                  opr_q   <= sel_bin_d;
                  acc_q   <= 20'd0;
                  cnt_q   <= 4'd0;
                  ack_q   <= 4'b0001 << arb_idx_d;
                  state_q <= CONV;
               end
            end
            CONV: begin
               acc_q <= acc_d;
               opr_q <= opr_d;
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_q <= DONE;
                  valid_q <= 1'b1;
                  id_q    <= gnt_q;
                  bcd_q   <= res_bcd_d;
                  ovf_q   <= res_ovf_d;
               end
            end
            DONE: begin
               ptr_q   <= gnt_q + 2'd1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack        = ack_q;
   assign busy       = (state_q != IDLE);
   assign dout_valid = valid_q;
   assign dout_id    = id_q;
   assign dout_bcd   = bcd_q;
   assign dout_ovf   = ovf_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Bench for bcd_conv_sched: a saturating and a truncating instance share all
// stimulus. Drivers push expected grants/results into queues; an independent
// monitor pops and compares whenever the DUTs present ack or dout_valid.
module tb_bcd_conv_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] bin_a [4];

  logic [3:0]  ack_s, ack_t;
  logic        busy_s, busy_t;
  logic        valid_s, valid_t;
  logic [1:0]  id_s, id_t;
  logic [15:0] bcd_s, bcd_t;
  logic        ovf_s, ovf_t;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          model_ptr = 0;

  // expected result: {id[1:0], ovf, bcd_saturating[15:0], bcd_truncating[15:0]}
  logic [34:0] exp_q[$];
  logic [3:0]  ack_exp_q[$];
  int unsigned ack_cyc_q[$];

  bcd_conv_sched #(.SAT_EN(1'b1)) dut_s (
    .clk(clk), .rst(rst), .req(req),
    .bin0(bin_a[0]), .bin1(bin_a[1]), .bin2(bin_a[2]), .bin3(bin_a[3]),
    .ack(ack_s), .busy(busy_s), .dout_valid(valid_s),
    .dout_id(id_s), .dout_bcd(bcd_s), .dout_ovf(ovf_s)
  );

  bcd_conv_sched #(.SAT_EN(1'b0)) dut_t (
    .clk(clk), .rst(rst), .req(req),
    .bin0(bin_a[0]), .bin1(bin_a[1]), .bin2(bin_a[2]), .bin3(bin_a[3]),
    .ack(ack_t), .busy(busy_t), .dout_valid(valid_t),
    .dout_id(id_t), .dout_bcd(bcd_t), .dout_ovf(ovf_t)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // decimal digits packed as BCD, from plain arithmetic
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [34:0] model(input int id, input int v);
    logic ovf;
    logic [15:0] sat;
    ovf = (v > 9999);
    sat = ovf ? 16'h9999 : to_bcd(v);
    return {2'(id), ovf, sat, to_bcd(v % 10000)};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (ack_s != 4'd0 || ack_t != 4'd0) begin
        if (ack_exp_q.size() == 0) begin
          check("unexpected_ack", {ack_s, ack_t}, 32'd0);
        end else begin
          logic [3:0] ea;
          ea = ack_exp_q.pop_front();
          check("ack_sat", ack_s, ea);
          check("ack_trunc", ack_t, ea);
          ack_cyc_q.push_back(cyc);
        end
      end
      if (valid_s || valid_t) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {valid_s, valid_t}, 32'd0);
        end else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          check("valid_pair", {valid_s, valid_t}, 32'd3);
          check("dout_id", {id_s, id_t}, {e[34:33], e[34:33]});
          check("dout_ovf", {ovf_s, ovf_t}, {e[32], e[32]});
          check("dout_bcd_sat", bcd_s, e[31:16]);
          check("dout_bcd_trunc", bcd_t, e[15:0]);
          if (ack_cyc_q.size() != 0) check("latency", cyc - ack_cyc_q.pop_front(), 32'd16);
          else check("latency_no_ack", 32'd0, 32'd1);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, {ack_s, ack_t}, 32'd0);
    check({tag, "_busy_valid"}, {busy_s, busy_t, valid_s, valid_t}, 32'd0);
    check({tag, "_id_ovf"}, {id_s, id_t, ovf_s, ovf_t}, 32'd0);
    check({tag, "_bcd"}, {bcd_s, bcd_t}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 4'd0;
    model_ptr = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 60;
    while (busy_s && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  // Assert mask; each requester drops its req on its ack. Grants must come
  // in round-robin order from the model pointer, 18 cycles apart.
  task automatic run_batch(input logic [3:0] mask);
    int budget, last, prev;
    last = model_ptr;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (model_ptr + k) % 4;
      if (mask[idx]) begin
        ack_exp_q.push_back(4'(1 << idx));
        exp_q.push_back(model(idx, int'(bin_a[idx])));
        last = idx;
      end
    end
    model_ptr = (last + 1) % 4;
    @(negedge clk);
    req = mask;
    budget = 100;
    prev = -1;
    while (req != 4'd0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (ack_s != 4'd0) begin
        req = req & ~ack_s;
        check("busy_in_conv", busy_s, 32'd1);
        if (prev >= 0) check("grant_gap", cyc - prev, 32'd18);
        prev = int'(cyc);
      end
    end
    if (budget == 0) begin
      check("batch_timeout", req, 32'd0);
      req = 4'd0;
    end
    wait_idle();
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic single(input int id, input logic [15:0] v);
    bin_a[id] = v;
    run_batch(4'(1 << id));
  endtask

  task automatic randomize_bins();
    for (int i = 0; i < 4; i++)
      bin_a[i] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 9999))
                                             : 16'($urandom_range(0, 65535));
  endtask

  // req0 and req2 held high: grants alternate 0,2,... and 1,3 never win
  task automatic hold_0_2();
    int budget, seen, prev;
    randomize_bins();
    for (int k = 0; k < 6; k++) begin
      int idx;
      idx = (k % 2 == 0) ? 0 : 2;
      ack_exp_q.push_back(4'(1 << idx));
      exp_q.push_back(model(idx, int'(bin_a[idx])));
    end
    model_ptr = 3;
    @(negedge clk);
    req = 4'b0101;
    budget = 200;
    seen = 0;
    prev = -1;
    while (seen < 6 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (ack_s != 4'd0) begin
        seen++;
        if (prev >= 0) check("hold_gap", cyc - prev, 32'd18);
        prev = int'(cyc);
      end
    end
    req = 4'd0;
    if (budget == 0) check("hold_timeout", seen, 32'd6);
    wait_idle();
    check("hold_drained", exp_q.size(), 32'd0);
  endtask

  // reset in the 8th CONV cycle; the aborted job must vanish and ptr restart at 0
  task automatic abort_test();
    int budget;
    bin_a[1] = 16'd4321;
    run_batch(4'b0010);        // leaves pointer at 2 and a nonzero held result
    bin_a[3] = 16'd5678;
    ack_exp_q.push_back(4'b1000);
    exp_q.push_back(model(3, 5678));
    @(negedge clk);
    req = 4'b1000;
    budget = 10;
    do begin
      @(negedge clk);
      budget--;
    end while (ack_s == 4'd0 && budget > 0);
    if (budget == 0) check("abort_ack_timeout", 32'd1, 32'd0);
    req = 4'd0;
    repeat (7) @(negedge clk);
    #1 rst = 1'b0;
    #1 check_zero("abort");
    void'(exp_q.pop_back());
    if (ack_cyc_q.size() != 0) void'(ack_cyc_q.pop_back());
    model_ptr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    randomize_bins();
    run_batch(4'b0110);        // ptr 0 after reset: requester 1 before 2
  endtask

  initial begin
    rst = 1'b0;
    req = 4'd0;
    for (int i = 0; i < 4; i++) bin_a[i] = 16'd0;
    repeat (3) @(negedge clk);
    check_zero("power_on");
    rst = 1'b1;

    single(0, 16'd1234);
    single(1, 16'd0);
    single(2, 16'd9);
    single(3, 16'd10);
    single(0, 16'd9999);
    single(2, 16'd10000);
    single(1, 16'd65535);

    do_reset();
    randomize_bins();
    run_batch(4'b1111);

    do_reset();
    hold_0_2();

    for (int n = 0; n < 12; n++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      randomize_bins();
      run_batch(m);
    end

    abort_test();

    repeat (5) @(negedge clk);
    check("final_exp_empty", exp_q.size(), 32'd0);
    check("final_ack_empty", ack_exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
